// File: rtl/vigna_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// vigna_bus_arbiter_if
//   Bundles the instruction port, the data port and the shared memory bus of
//   the vigna two-master arbiter.
//   Modports:
//     slave  - the arbiter's view: it accepts core requests on i_* / d_*,
//              issues them on m_*, and reports aborts on bus_err.
//     master - the environment's view (core + memory side), the mirror image.
//   Signals:
//     i_valid/i_ready/i_addr/i_rdata                       instruction fetch port
//     d_valid/d_ready/d_addr/d_rdata/d_wdata/d_wstrb       data port (wstrb 0 = read)
//     m_valid/m_ready/m_addr/m_rdata/m_wdata/m_wstrb       shared bus
//     bus_err                                              one-cycle abort pulse
// -----------------------------------------------------------------------------
interface vigna_bus_arbiter_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_rdata;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  logic        bus_err;

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rdata,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata,
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata,
    output bus_err
  );

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rdata,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata,
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata,
    input  bus_err
  );
endinterface

// File: rtl/vigna_bus_arbiter.sv
// -----------------------------------------------------------------------------
// vigna_bus_arbiter
//   Merges the vigna core's instruction and data ports onto one shared memory
//   bus. One transaction is outstanding at a time: a request is registered onto
//   the shared bus, the slave's answer is captured, and the requesting port gets
//   a one-cycle ready pulse. A programmable timeout aborts a transaction whose
//   slave never answers, returning zero data and pulsing bus_err.
//   Parameters:
//     PRIORITY - 0: round-robin on ties, 1: data port wins every tie
//     TIMEOUT  - BUSY cycles before abort, 0 disables the timeout
//     CNT_W    - timeout counter width, TIMEOUT must be below 2**CNT_W
//   Ports:
//     clk    - clock, rising edge
//     resetn - asynchronous active-low reset
//     bus    - instruction, data and shared-bus signals (slave modport)
// -----------------------------------------------------------------------------
module vigna_bus_arbiter #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               resetn,
  vigna_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_d;
  port_t            last_grant;  // also the port owning the current transaction
  port_t            pick;
  logic             do_grant;
  logic             do_done;
  logic             do_abort;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;

  logic        i_ready_q;
  logic [31:0] i_rdata_q;
  logic        d_ready_q;
  logic [31:0] d_rdata_q;
  logic        m_valid_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [3:0]  m_wstrb_q;
  logic        bus_err_q;

  // Arbitration: a lone requester always wins; on a tie either the data port
  // wins outright or the port that was not served last time wins.
  always_comb begin
    pick = PORT_I;
    if (bus.d_valid && !bus.i_valid) begin
      pick = PORT_D;
    end else if (bus.d_valid && bus.i_valid) begin
      if (PRIORITY != 0) pick = PORT_D;
      else               pick = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid || bus.d_valid) begin
          do_grant = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ready) begin
          do_done = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // NOTE: everything, including the rdata holding registers, is reset: the
  // outputs must read zero the moment resetn falls, not after a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= PORT_D;  // makes the first tie go to the instruction port
      cnt        <= '0;
      i_ready_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_ready_q  <= 1'b0;
      d_rdata_q  <= '0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      // Ready and error are single-cycle pulses.
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      bus_err_q <= 1'b0;

      if (do_grant) begin
        last_grant <= pick;
        cnt        <= '0;
        m_valid_q  <= 1'b1;
        if (pick == PORT_D) begin
          m_addr_q  <= bus.d_addr;
          m_wdata_q <= bus.d_wdata;
          m_wstrb_q <= bus.d_wstrb;
        end else begin
          m_addr_q  <= bus.i_addr;
          m_wdata_q <= '0;
          m_wstrb_q <= '0;
        end
      end

      if (do_done || do_abort) begin
        m_valid_q <= 1'b0;
        m_wstrb_q <= '0;
        bus_err_q <= do_abort;
        // An aborted transaction returns zero instead of whatever is on m_rdata.
        if (last_grant == PORT_D) begin
          d_ready_q <= 1'b1;
          d_rdata_q <= do_done ? bus.m_rdata : 32'h0;
        end else begin
          i_ready_q <= 1'b1;
          i_rdata_q <= do_done ? bus.m_rdata : 32'h0;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.bus_err = bus_err_q;

endmodule
